parking_gate_scheduler: RTL and testbench
=========================================

# parking_gate_scheduler

Shares a single barrier gate among NUM_LANES entry lanes and NUM_LANES exit lanes of the parking lot. Requests are arbitrated round-robin within each direction and exits are ordered against entries. Each granted car gets one timed gate-open window. The block owns the occupancy count and blocks entries while the lot is full. It sits between the lane sensors (already debounced and level-held) and the gate actuator.

## Interface
- NUM_LANES, 4: number of entry lanes, and separately the number of exit lanes; ≥2.
- CAPACITY, 8: maximum occupancy; ≥1.
- OPEN_CYCLES, 4: cycles gate_open stays high per grant; ≥1.
- Derived: OW = $clog2(CAPACITY+1).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- enter_req  in  NUM_LANES  per-lane entry request; level, held until that lane's grant.
- exit_req  in  NUM_LANES  per-lane exit request; level, held until that lane's grant.
- enter_grant  out  NUM_LANES  one-hot, one-cycle pulse to the granted entry lane.
- exit_grant  out  NUM_LANES  one-hot, one-cycle pulse to the granted exit lane.
- gate_open  out  1  gate actuator drive.
- gate_dir  out  1  0 = entry pass, 1 = exit pass; valid while gate_open.
- occupancy  out  OW  cars currently inside.
- lot_full  out  1  occupancy == CAPACITY.
- busy  out  1  high in any state other than IDLE.

## Operation
- All outputs are registered.
- Reset values:
  - state IDLE.
  - Both round-robin pointers = 0.
  - occupancy = 0.
  - All grants, gate_open, gate_dir, lot_full and busy = 0.
  - Direction-history bit = "last granted was entry".
- The state machine has three states: IDLE, OPEN and CLEAR.
- IDLE, arbitration at each clock edge:
  - An entry candidate is any enter_req bit, only if occupancy < CAPACITY.
  - An exit candidate is any exit_req bit, only if occupancy > 0.
  - An exit_req while occupancy == 0 is ignored and never granted.
  - Within a direction, the search starts at that direction's pointer and wraps modulo NUM_LANES. The first set bit wins.
  - After granting lane i, that direction's pointer becomes (i+1) mod NUM_LANES. The other direction's pointer is unchanged.
  - Direction choice when both directions have candidates depends on the Configuration macro.
  - On a grant at the edge:
    - The grant bit is set for 1 cycle.
    - gate_open is set to 1 and gate_dir to the granted direction.
    - occupancy is incremented (entry) or decremented (exit) at that same edge.
    - lot_full is updated at that same edge.
    - state moves to OPEN and the open counter loads OPEN_CYCLES-1.
- OPEN:
  - gate_open = 1 and gate_dir is held.
  - The counter decrements each cycle. At 0 the next edge moves to CLEAR with gate_open = 0.
  - Requests are not sampled.
- CLEAR: lasts 1 cycle, gate_open = 0, then moves to IDLE.
- Requester rule: a lane drops its req in the cycle after its grant. A req still high on return to IDLE is treated as a new car.
- Occupancy never wraps. Entry is blocked at CAPACITY and exit is blocked at 0.

## Timing
- Request-to-grant latency: 1 edge when the block is in IDLE. A request raised during OPEN or CLEAR waits for IDLE.
- gate_open is high for exactly OPEN_CYCLES consecutive cycles, starting in the cycle the grant is visible.
- Grant-to-next-grant minimum spacing: OPEN_CYCLES+2 cycles (OPEN window, 1 CLEAR cycle, 1 IDLE cycle).
- occupancy and lot_full change only in the grant cycle.
- rst asserted mid-OPEN drops gate_open immediately (asynchronously) and restores all reset values.

## Configuration
- EXIT_PRIORITY_EN defined: when both directions have candidates, exit always wins. The direction-history bit is unused.
- EXIT_PRIORITY_EN undefined: when both directions have candidates, the direction opposite to the direction-history bit wins, so entry and exit alternate. The first contended grant after reset is exit. The history bit updates on every grant.
- Uncontended arbitration is identical in both builds.

## Test plan
Each scenario uses NUM_LANES=4, CAPACITY=2, OPEN_CYCLES=3.
- Single entry: enter_req=0b0100 in IDLE → enter_grant=0b0100 for 1 cycle; gate_open high 3 cycles with gate_dir=0; occupancy 0→1; next grant no earlier than 5 cycles later.
- Round-robin: enter_req=0b1011 held, each lane dropped after its own grant → grant order lanes 0, 1, then blocked at occupancy=2 (lot_full=1). After exits drain, the next grant goes to lane 3 (pointer at 2, wraps past lane 2 to 3).
- Full and empty: with occupancy=2, enter_req=0b0001 → no grant, busy=0. With occupancy=0, exit_req=0b0010 → no grant and occupancy stays 0.
- Contention at occupancy=1 with enter_req=0b0001 and exit_req=0b0001:
  - With EXIT_PRIORITY_EN: exit granted first (occupancy→0), then entry.
  - Without EXIT_PRIORITY_EN: exit first after reset, then entry, strictly alternating while both are held.
- Reset mid-operation: assert rst in the 2nd OPEN cycle → gate_open=0, occupancy=0 and pointers=0 immediately. After release, enter_req=0b1000 is granted lane 3 with occupancy=1.

Source files
------------

// File: rtl/parking_gate_scheduler.sv
// parking_gate_scheduler
//
// Shares one barrier gate between NUM_LANES entry lanes and NUM_LANES exit
// lanes. Each direction is arbitrated round-robin. Every granted car gets
// one gate-open window of OPEN_CYCLES cycles, then one CLEAR cycle. The
// block owns the occupancy count. It blocks entries while the lot is full
// and ignores exits while it is empty.
//
// Configuration macro: EXIT_PRIORITY_EN
//   defined   : under contention the exit always wins.
//   undefined : under contention the direction opposite to the last grant
//               wins, so entry and exit alternate. After reset, exit goes
//               first.
//
// Ports:
//   clk          in   clock
//   rst          in   asynchronous, active-high reset
//   enter_req    in   per-lane entry request (level, held until granted)
//   exit_req     in   per-lane exit request (level, held until granted)
//   enter_grant  out  one-hot, one-cycle entry grant pulse
//   exit_grant   out  one-hot, one-cycle exit grant pulse
//   gate_open    out  gate actuator drive
//   gate_dir     out  0 = entry pass, 1 = exit pass (valid while gate_open)
//   occupancy    out  cars currently inside
//   lot_full     out  occupancy == CAPACITY
//   busy         out  FSM not in IDLE
module parking_gate_scheduler #(
  parameter int NUM_LANES   = 4,
  parameter int CAPACITY    = 8,
  parameter int OPEN_CYCLES = 4,
  localparam int OW         = $clog2(CAPACITY + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] enter_req,
  input  logic [NUM_LANES-1:0] exit_req,
  output logic [NUM_LANES-1:0] enter_grant,
  output logic [NUM_LANES-1:0] exit_grant,
  output logic                 gate_open,
  output logic                 gate_dir,
  output logic [OW-1:0]        occupancy,
  output logic                 lot_full,
  output logic                 busy
);

  localparam int PW = $clog2(NUM_LANES);
  localparam int CW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
  localparam logic [OW-1:0] CAP_V    = OW'(CAPACITY);
  localparam logic [CW-1:0] CNT_LOAD = CW'(OPEN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, OPEN, CLEAR} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         enter_ptr_q, enter_ptr_d;
  logic [PW-1:0]         exit_ptr_q, exit_ptr_d;
  logic [OW-1:0]         occupancy_q, occupancy_d;
  logic                  lot_full_q, lot_full_d;
  logic [NUM_LANES-1:0]  enter_grant_q, enter_grant_d;
  logic [NUM_LANES-1:0]  exit_grant_q, exit_grant_d;
  logic                  gate_open_q, gate_open_d;
  logic                  gate_dir_q, gate_dir_d;
  logic                  busy_q, busy_d;
`ifndef EXIT_PRIORITY_EN
  // 1 = last grant was an exit; reset value means "last was entry".
  logic                  hist_q, hist_d;
`endif

  logic [NUM_LANES-1:0]  enter_pick, exit_pick;
  logic                  entry_cand, exit_cand, pick_exit;

  // First set bit at or after ptr, wrapping modulo NUM_LANES.
  function automatic logic [NUM_LANES-1:0] rr_pick(input logic [NUM_LANES-1:0] req,
                                                   input logic [PW-1:0] ptr);
    logic [NUM_LANES-1:0] onehot;
    logic found;
    int idx;
    onehot = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = (int'(ptr) + k) % NUM_LANES;
      if (!found && req[idx]) begin
        onehot[idx] = 1'b1;
        found       = 1'b1;
      end
    end
    return onehot;
  endfunction

  // Pointer moves to the lane just after the winner.
  function automatic logic [PW-1:0] rr_next(input logic [NUM_LANES-1:0] onehot,
                                            input logic [PW-1:0] ptr);
    logic [PW-1:0] p;
    p = ptr;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (onehot[i]) p = PW'((i + 1) % NUM_LANES);
    end
    return p;
  endfunction

  always_comb begin
    enter_pick = rr_pick(enter_req, enter_ptr_q);
    exit_pick  = rr_pick(exit_req, exit_ptr_q);
    entry_cand = (|enter_req) && (occupancy_q < CAP_V);
    exit_cand  = (|exit_req) && (occupancy_q != '0);
`ifdef EXIT_PRIORITY_EN
    pick_exit  = exit_cand;
`else
    if (entry_cand && exit_cand) pick_exit = ~hist_q;
    else                         pick_exit = exit_cand;
`endif
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    enter_ptr_d   = enter_ptr_q;
    exit_ptr_d    = exit_ptr_q;
    occupancy_d   = occupancy_q;
    lot_full_d    = lot_full_q;
    enter_grant_d = '0;
    exit_grant_d  = '0;
    gate_open_d   = 1'b0;
    gate_dir_d    = gate_dir_q;
`ifndef EXIT_PRIORITY_EN
    hist_d        = hist_q;
`endif
    case (state_q)
      IDLE: begin
        if (entry_cand || exit_cand) begin
          state_d     = OPEN;
          cnt_d       = CNT_LOAD;
          gate_open_d = 1'b1;
          gate_dir_d  = pick_exit;
          if (pick_exit) begin
            exit_grant_d = exit_pick;
            exit_ptr_d   = rr_next(exit_pick, exit_ptr_q);
            occupancy_d  = occupancy_q - OW'(1);
          end else begin
            enter_grant_d = enter_pick;
            enter_ptr_d   = rr_next(enter_pick, enter_ptr_q);
            occupancy_d   = occupancy_q + OW'(1);
          end
          lot_full_d = (occupancy_d == CAP_V);
`ifndef EXIT_PRIORITY_EN
          hist_d = pick_exit;
`endif
        end
      end
      OPEN: begin
        // The grant cycle already counts as the first open cycle.
        gate_open_d = 1'b1;
        if (cnt_q == '0) begin
          state_d     = CLEAR;
          gate_open_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      enter_ptr_q   <= '0;
      exit_ptr_q    <= '0;
      occupancy_q   <= '0;
      lot_full_q    <= 1'b0;
      enter_grant_q <= '0;
      exit_grant_q  <= '0;
      gate_open_q   <= 1'b0;
      gate_dir_q    <= 1'b0;
      busy_q        <= 1'b0;
`ifndef EXIT_PRIORITY_EN
      hist_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      enter_ptr_q   <= enter_ptr_d;
      exit_ptr_q    <= exit_ptr_d;
      occupancy_q   <= occupancy_d;
      lot_full_q    <= lot_full_d;
      enter_grant_q <= enter_grant_d;
      exit_grant_q  <= exit_grant_d;
      gate_open_q   <= gate_open_d;
      gate_dir_q    <= gate_dir_d;
      busy_q        <= busy_d;
`ifndef EXIT_PRIORITY_EN
      hist_q        <= hist_d;
`endif
    end
  end

  assign enter_grant = enter_grant_q;
  assign exit_grant  = exit_grant_q;
  assign gate_open   = gate_open_q;
  assign gate_dir    = gate_dir_q;
  assign occupancy   = occupancy_q;
  assign lot_full    = lot_full_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Testbench for parking_gate_scheduler with NUM_LANES=4, CAPACITY=2 and
// OPEN_CYCLES=3. A table of single transactions runs from reset. Each
// record gives the requests and the expected grant-cycle outputs. Hand
// sequences then cover gate-window timing, grant spacing and reset
// during OPEN. Expected contention results follow EXIT_PRIORITY_EN.
module tb_parking_gate_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] enter_req;
  logic [3:0] exit_req;
  logic [3:0] enter_grant;
  logic [3:0] exit_grant;
  logic       gate_open;
  logic       gate_dir;
  logic [1:0] occupancy;
  logic       lot_full;
  logic       busy;

  int compared;
  int mismatched;

  typedef struct {
    logic [3:0] enter_req;
    logic [3:0] exit_req;
    logic [3:0] exp_eg;
    logic [3:0] exp_xg;
    logic       exp_open;
    logic       exp_dir;
    logic [1:0] exp_occ;
    logic       exp_full;
  } vec_t;

  vec_t vecs[16];

  parking_gate_scheduler #(
    .NUM_LANES(4),
    .CAPACITY(2),
    .OPEN_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enter_req(enter_req),
    .exit_req(exit_req),
    .enter_grant(enter_grant),
    .exit_grant(exit_grant),
    .gate_open(gate_open),
    .gate_dir(gate_dir),
    .occupancy(occupancy),
    .lot_full(lot_full),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] expd);
    compared++;
    if (act !== expd) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expd);
    end
  endtask

  // Pulse reset across a couple of edges and leave the bench on a negedge.
  task automatic doReset();
    enter_req = '0;
    exit_req  = '0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    checkOutput("idle_timeout", 8'(busy), 8'd0);
  endtask

  // One table record: drive requests on a negedge, let one edge arbitrate,
  // check the grant-cycle outputs, drop the requests and drain to IDLE.
  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    tag       = $sformatf("vec%0d", idx);
    enter_req = v.enter_req;
    exit_req  = v.exit_req;
    @(negedge clk);
    checkOutput({tag, "_enter_grant"}, 8'(enter_grant), 8'(v.exp_eg));
    checkOutput({tag, "_exit_grant"}, 8'(exit_grant), 8'(v.exp_xg));
    checkOutput({tag, "_gate_open"}, 8'(gate_open), 8'(v.exp_open));
    checkOutput({tag, "_busy"}, 8'(busy), 8'(v.exp_open));
    if (v.exp_open) checkOutput({tag, "_gate_dir"}, 8'(gate_dir), 8'(v.exp_dir));
    checkOutput({tag, "_occupancy"}, 8'(occupancy), 8'(v.exp_occ));
    checkOutput({tag, "_lot_full"}, 8'(lot_full), 8'(v.exp_full));
    enter_req = '0;
    exit_req  = '0;
    waitIdle();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    enter_req  = '0;
    exit_req   = '0;

    //             enter    exit     eg       xg       open  dir   occ    full
    vecs[0]  = '{4'b1011, 4'b0000, 4'b0001, 4'b0000, 1'b1, 1'b0, 2'd1, 1'b0};
    vecs[1]  = '{4'b1010, 4'b0000, 4'b0010, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b1};
    vecs[2]  = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b1};
    vecs[3]  = '{4'b0000, 4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b0};
    vecs[4]  = '{4'b0000, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0};
    vecs[5]  = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0};
    vecs[6]  = '{4'b1000, 4'b0000, 4'b1000, 4'b0000, 1'b1, 1'b0, 2'd1, 1'b0};
    vecs[7]  = '{4'b0000, 4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b1, 2'd0, 1'b0};
    vecs[8]  = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b1, 1'b0, 2'd1, 1'b0};
    vecs[9]  = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0};
    vecs[10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0, 2'd1, 1'b0};
    vecs[11] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0};
    vecs[12] = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 1'b1, 1'b0, 2'd1, 1'b0};
    vecs[13] = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b1};
    vecs[14] = '{4'b0000, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b1, 2'd1, 1'b0};
`ifdef EXIT_PRIORITY_EN
    vecs[15] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b0};
`else
    vecs[15] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b1};
`endif

    // Reset state while rst is still asserted
    rst = 1'b1;
    #12;
    checkOutput("rst_enter_grant", 8'(enter_grant), 8'd0);
    checkOutput("rst_exit_grant", 8'(exit_grant), 8'd0);
    checkOutput("rst_gate_open", 8'(gate_open), 8'd0);
    checkOutput("rst_gate_dir", 8'(gate_dir), 8'd0);
    checkOutput("rst_occupancy", 8'(occupancy), 8'd0);
    checkOutput("rst_lot_full", 8'(lot_full), 8'd0);
    checkOutput("rst_busy", 8'(busy), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) applyStimulus(vecs[i], i);

    // Single entry held past its window: 3 open cycles, CLEAR, IDLE, and a
    // second grant exactly 5 cycles after the first.
    doReset();
    enter_req = 4'b0100;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checkOutput($sformatf("hold_c%0d_enter_grant", c), 8'(enter_grant),
                  (c == 1 || c == 6) ? 8'h04 : 8'h00);
      checkOutput($sformatf("hold_c%0d_gate_open", c), 8'(gate_open),
                  (c <= 3 || c == 6) ? 8'd1 : 8'd0);
      checkOutput($sformatf("hold_c%0d_busy", c), 8'(busy), (c == 5) ? 8'd0 : 8'd1);
      checkOutput($sformatf("hold_c%0d_occupancy", c), 8'(occupancy), (c == 6) ? 8'd2 : 8'd1);
      checkOutput($sformatf("hold_c%0d_lot_full", c), 8'(lot_full), (c == 6) ? 8'd1 : 8'd0);
      if (c <= 3) checkOutput($sformatf("hold_c%0d_gate_dir", c), 8'(gate_dir), 8'd0);
    end
    enter_req = '0;
    waitIdle();

    // Reset asserted in the 2nd OPEN cycle drops everything at once.
    doReset();
    enter_req = 4'b0010;
    @(negedge clk);
    checkOutput("midrst_grant", 8'(enter_grant), 8'h02);
    enter_req = '0;
    @(posedge clk);
    #2;
    checkOutput("midrst_open_before", 8'(gate_open), 8'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_gate_open", 8'(gate_open), 8'd0);
    checkOutput("midrst_occupancy", 8'(occupancy), 8'd0);
    checkOutput("midrst_busy", 8'(busy), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    enter_req = 4'b1000;
    @(negedge clk);
    checkOutput("postrst_enter_grant", 8'(enter_grant), 8'h08);
    checkOutput("postrst_occupancy", 8'(occupancy), 8'd1);
    enter_req = '0;
    waitIdle();
    // Entry pointer was reset to 0, so lanes 1 and 2 competing pick lane 1.
    enter_req = 4'b0110;
    @(negedge clk);
    checkOutput("postrst_ptr_grant", 8'(enter_grant), 8'h02);
    enter_req = '0;
    waitIdle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
